// File: rtl/movement_sequencer.sv
// Frame sequencer time-sharing the movement datapath between player crosshair and bird.
// Optional watchdog on clear/draw waits: define MOVESEQ_WATCHDOG_EN.
module movement_sequencer #(
    parameter int unsigned BIRD_DIV = 2,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_tick,
    input  logic       p_left,
    input  logic       p_right,
    input  logic       p_up,
    input  logic       p_down,
    input  logic [1:0] b_dx,
    input  logic [1:0] b_dy,
    input  logic       enable,
    input  logic       leave,
    output logic [3:0] control,
    output logic       PorB,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun,
    output logic [3:0] escapes,
    output logic       err
);

    typedef enum logic [2:0] {StHold, StPre, StClr, StMovX, StMovY, StDrw, StDone} state_e;

    localparam logic [3:0] CtlHold    = 4'b0000;
    localparam logic [3:0] CtlPrehold = 4'b0100;
    localparam logic [3:0] CtlClear   = 4'b0001;
    localparam logic [3:0] CtlLeft    = 4'b0011;
    localparam logic [3:0] CtlRight   = 4'b0010;
    localparam logic [3:0] CtlDown    = 4'b0110;
    localparam logic [3:0] CtlUp      = 4'b0111;
    localparam logic [3:0] CtlDraw    = 4'b0101;

    localparam int unsigned FcW = (BIRD_DIV > 1) ? $clog2(BIRD_DIV) : 1;

    state_e         state_q, state_d;
    logic           slot_q, slot_d;
    logic           bird_due_q, bird_due_d;
    logic [FcW-1:0] frame_cnt_q, frame_cnt_d;
    logic           first_q;
    logic [3:0]     mov_x_q, mov_x_d;
    logic [3:0]     mov_y_q, mov_y_d;
    logic [3:0]     dir_x, dir_y;
    logic [3:0]     control_d;
    logic           porb_d;
    logic           en_ok;
    logic           timeout;
    logic           leave_q;

    // The datapath still holds enable from the previous draw on the first wait cycle.
    assign en_ok = enable & ~first_q;

    always_comb begin
        dir_x = CtlHold;
        dir_y = CtlHold;
        if (slot_q) begin
            if (b_dx == 2'b01)      dir_x = CtlRight;
            else if (b_dx == 2'b10) dir_x = CtlLeft;
            if (b_dy == 2'b01)      dir_y = CtlDown;
            else if (b_dy == 2'b10) dir_y = CtlUp;
        end else begin
            if (p_right && !p_left)     dir_x = CtlRight;
            else if (p_left && !p_right) dir_x = CtlLeft;
            if (p_down && !p_up)        dir_y = CtlDown;
            else if (p_up && !p_down)   dir_y = CtlUp;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        bird_due_d  = bird_due_q;
        frame_cnt_d = frame_cnt_q;
        mov_x_d     = mov_x_q;
        mov_y_d     = mov_y_q;

        unique case (state_q)
            StHold: begin
                if (frame_tick) begin
                    state_d     = StPre;
                    slot_d      = 1'b0;
                    bird_due_d  = (frame_cnt_q == '0);
                    frame_cnt_d = (frame_cnt_q == FcW'(BIRD_DIV - 1)) ? '0 : frame_cnt_q + 1'b1;
                end
            end
            StPre:  state_d = StClr;
            StClr: begin
                if (en_ok) begin
                    state_d = StMovX;
                    mov_x_d = dir_x;
                    mov_y_d = dir_y;
                end else if (timeout) begin
                    state_d = StDone;
                end
            end
            StMovX: state_d = StMovY;
            StMovY: state_d = StDrw;
            StDrw: begin
                if (en_ok) begin
                    if (!slot_q && bird_due_q) begin
                        state_d = StPre;
                        slot_d  = 1'b1;
                    end else begin
                        state_d = StDone;
                    end
                end else if (timeout) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StHold;
            default: state_d = StHold;
        endcase

        // Outputs are registered from the next state so they line up with the state register.
        control_d = CtlHold;
        porb_d    = PorB;
        case (state_d)
            StPre: begin
                control_d = CtlPrehold;
                porb_d    = slot_d;
            end
            StClr:  control_d = CtlClear;
            StMovX: control_d = mov_x_d;
            StMovY: control_d = mov_y_d;
            StDrw:  control_d = CtlDraw;
            StDone: porb_d    = 1'b0;
            default: control_d = CtlHold;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StHold;
            slot_q      <= 1'b0;
            bird_due_q  <= 1'b0;
            frame_cnt_q <= '0;
            first_q     <= 1'b0;
            mov_x_q     <= CtlHold;
            mov_y_q     <= CtlHold;
            control     <= CtlHold;
            PorB        <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            bird_due_q  <= bird_due_d;
            frame_cnt_q <= frame_cnt_d;
            first_q     <= (state_d != state_q) && ((state_d == StClr) || (state_d == StDrw));
            mov_x_q     <= mov_x_d;
            mov_y_q     <= mov_y_d;
            control     <= control_d;
            PorB        <= porb_d;
            busy        <= (state_d != StHold);
            frame_done  <= (state_d == StDone);
            overrun     <= frame_tick && (state_q != StHold);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leave_q <= 1'b0;
            escapes <= 4'd0;
        end else begin
            leave_q <= leave;
            if (leave && !leave_q && (escapes != 4'hF)) escapes <= escapes + 4'd1;
        end
    end

`ifdef MOVESEQ_WATCHDOG_EN
    localparam int unsigned WdW = $clog2(TIMEOUT + 1);

    logic [WdW-1:0] wd_cnt_q;

    assign timeout = (wd_cnt_q == WdW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= '0;
            err      <= 1'b0;
        end else begin
            if (state_d != state_q)                           wd_cnt_q <= '0;
            else if ((state_q == StClr) || (state_q == StDrw)) wd_cnt_q <= wd_cnt_q + 1'b1;
            err <= timeout && !en_ok && ((state_q == StClr) || (state_q == StDrw));
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule
